// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Variable shifts (ops 8/9) iterate one bit per cycle in BUSY.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z, n, c, v;
  } rsp_t;

  state_t           state, state_nxt;
  rsp_t             rsp, rsp_c;
  logic [WIDTH-1:0] acc, acc_nxt, r;
  logic [WIDTH:0]   sum, dif;
  logic [SW-1:0]    cnt, amt;
  logic             dir, shout, shift_op, live_op;

  assign amt      = b[SW-1:0];
  assign shift_op = (op == 4'd8) || (op == 4'd9);
  assign live_op  = (op < 4'd12);

  // single-cycle result; shift ops land here only when the amount is 0
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    r     = '0;
    rsp_c = '0;
    case (op)
      4'd1: begin
        r       = sum[WIDTH-1:0];
        rsp_c.c = sum[WIDTH];
        rsp_c.v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: begin
        r       = dif[WIDTH-1:0];
        rsp_c.c = dif[WIDTH];
        rsp_c.v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: begin
        r       = {a[WIDTH-2:0], 1'b0};
        rsp_c.c = a[WIDTH-1];
      end
      4'd4: begin
        r       = {1'b0, a[WIDTH-1:1]};
        rsp_c.c = a[0];
      end
      4'd5:       r = a & b;
      4'd6:       r = a | b;
      4'd7:       r = a ^ b;
      4'd8, 4'd9: r = a;
      4'd10:      r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd11:      r = {{(WIDTH-1){1'b0}}, (a < b)};
      default:    r = '0;
    endcase
    rsp_c.res = r;
    rsp_c.z   = live_op && (r == '0);
    rsp_c.n   = live_op && r[WIDTH-1];
  end

  // dir=1 shifts right
  assign acc_nxt = dir ? {1'b0, acc[WIDTH-1:1]} : {acc[WIDTH-2:0], 1'b0};
  assign shout   = dir ? acc[0] : acc[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (shift_op && amt != '0) ? BUSY : DONE;
      BUSY: if (cnt == SW'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp <= '0;
      acc <= '0;
      cnt <= '0;
      dir <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (shift_op && amt != '0) begin
            acc   <= a;
            cnt   <= amt;
            dir   <= op[0];
            rsp.c <= 1'b0;
            rsp.v <= 1'b0;
          end else begin
            rsp <= rsp_c;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          cnt   <= cnt - SW'(1);
          rsp.c <= shout;
          if (cnt == SW'(1)) begin
            rsp.res <= acc_nxt;
            rsp.z   <= (acc_nxt == '0);
            rsp.n   <= acc_nxt[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign result = rsp.res;
  assign flag_z = rsp.z;
  assign flag_n = rsp.n;
  assign flag_c = rsp.c;
  assign flag_v = rsp.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector table plus hand sequences for backpressure and mid-shift reset.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   op;
  logic         flag_z, flag_n, flag_c, flag_v;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // fl = {z, n, c, v}
  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] top,
                       output int lat, output int busy);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    in_valid = 1'b1; a = ta; b = tb_; op = top;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h5555_5555; op = 4'd1;  // post-accept changes must not matter
    lat = 1; busy = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, busy;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd1,  32'h0000_0000, 4'b1010, 1};
    tbl[1]  = '{32'h8000_0000, 32'h0000_0001, 4'd2,  32'h7FFF_FFFF, 4'b0001, 1};
    tbl[2]  = '{32'h0000_0003, 32'd31,        4'd8,  32'h8000_0000, 4'b0110, 32};
    tbl[3]  = '{32'hF0F0_F0F0, 32'hFFFF_0000, 4'd7,  32'h0F0F_F0F0, 4'b0000, 1};
    tbl[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd10, 32'h0000_0001, 4'b0000, 1};
    tbl[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd11, 32'h0000_0000, 4'b1000, 1};
    tbl[6]  = '{32'h0000_1234, 32'h0000_5678, 4'd0,  32'h0000_0000, 4'b1000, 1};
    tbl[7]  = '{32'h8000_0001, 32'h0000_0000, 4'd3,  32'h0000_0002, 4'b0010, 1};
    tbl[8]  = '{32'h0000_0003, 32'h0000_0000, 4'd4,  32'h0000_0001, 4'b0010, 1};
    tbl[9]  = '{32'hFF00_FF00, 32'h0F0F_0F0F, 4'd5,  32'h0F00_0F00, 4'b0000, 1};
    tbl[10] = '{32'hFF00_FF00, 32'h0F0F_0F0F, 4'd6,  32'hFF0F_FF0F, 4'b0100, 1};
    tbl[11] = '{32'h0000_0000, 32'h0000_0000, 4'd12, 32'h0000_0000, 4'b0000, 1};
    tbl[12] = '{32'h8000_0000, 32'h0000_0020, 4'd9,  32'h8000_0000, 4'b0100, 1};
    tbl[13] = '{32'h0000_0010, 32'h0000_0005, 4'd9,  32'h0000_0000, 4'b1010, 6};
    tbl[14] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd1,  32'h8000_0000, 4'b0101, 1};
    tbl[15] = '{32'h0000_0001, 32'h0000_0002, 4'd2,  32'hFFFF_FFFF, 4'b0110, 1};
    tbl[16] = '{32'h0000_0001, 32'h0000_0001, 4'd8,  32'h0000_0002, 4'b0000, 2};
    tbl[17] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0000_0000, 4'b0000, 1};
    tbl[18] = '{32'h0000_0001, 32'hFFFF_FFFF, 4'd10, 32'h0000_0000, 4'b1000, 1};
    tbl[19] = '{32'h0000_0001, 32'hFFFF_FFFF, 4'd11, 32'h0000_0001, 4'b0000, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready",  32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result",    result, 32'd0);
    chk("reset flags",     32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);

    for (int i = 0; i < 20; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].op, lat, busy);
      chk($sformatf("v%0d result", i), result, tbl[i].res);
      chk($sformatf("v%0d flags", i), 32'({flag_z, flag_n, flag_c, flag_v}), 32'(tbl[i].fl));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d busy cycles", i), 32'(busy), 32'(tbl[i].lat - 1));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d in_ready after handoff", i), 32'(in_ready), 32'd1);
    end

    // backpressure: result must hold while new traffic is refused
    out_ready = 1'b0;
    issue(32'hF0F0_F0F0, 32'hFFFF_0000, 4'd7, lat, busy);
    in_valid = 1'b1; a = 32'h1; b = 32'h1; op = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp hold result c%0d", k), result, 32'h0F0F_F0F0);
      chk($sformatf("bp in_ready c%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp out_valid c%0d", k), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp idle in_ready", 32'(in_ready), 32'd1);
    chk("bp idle out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp next out_valid", 32'(out_valid), 32'd1);
    chk("bp next result", result, 32'd2);
    @(posedge clk);
    @(negedge clk);

    // reset during the 5th BUSY cycle of a 20-bit right shift
    in_valid = 1'b1; a = 32'h8000_0000; b = 32'd20; op = 4'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("mid busy in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst result", result, 32'd0);
    chk("mid rst flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    issue(32'd2, 32'd3, 4'd1, lat, busy);
    chk("post rst add result", result, 32'd5);
    chk("post rst add latency", 32'(lat), 32'd1);
    @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
